process_page_controller: RTL and testbench

Upstream feeder of the memory management unit: owns the per-process base/limit table and produces the `Page` word and `BiosSign` that the MMU consumes. Also runs the context-switch sequence, the time-slice counter that raises preemption, and a registered bounds check on user-mode accesses. Sits between the OS-visible control interface and the MMU in the processor datapath.

---
 rtl/process_page_controller_pkg.sv | 28 ++
 rtl/process_page_controller_page_table_regs.sv | 33 +++
 rtl/process_page_controller.sv | 146 ++++++++++++++
 tb/tb_process_page_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/process_page_controller_pkg.sv
// rtl/process_page_controller_pkg.sv - shared types and Page word layout for the process page controller
package process_page_controller_pkg;

  localparam int PAGE_BASE_W    = 16;
  localparam int PAGE_LIMIT_W   = 16;
  localparam int PAGE_W         = PAGE_BASE_W + PAGE_LIMIT_W;
  localparam int PAGE_LIMIT_LSB = 0;
  localparam int PAGE_BASE_LSB  = PAGE_LIMIT_W;

  typedef enum logic [2:0] {
    ST_BIOS,
    ST_RUN,
    ST_DRAIN,
    ST_LOAD,
    ST_ACK
  } state_e;

  // Pack a base/limit pair into the Page word the MMU consumes
  function automatic logic [PAGE_W-1:0] make_page(input logic [PAGE_BASE_W-1:0]  base,
                                                  input logic [PAGE_LIMIT_W-1:0] limit);
    logic [PAGE_W-1:0] page;
    page = '0;
    page[PAGE_BASE_LSB +: PAGE_BASE_W]   = base;
    page[PAGE_LIMIT_LSB +: PAGE_LIMIT_W] = limit;
    return page;
  endfunction

endpackage

// File: rtl/process_page_controller_page_table_regs.sv
// rtl/process_page_controller_page_table_regs.sv - per-process base/limit register file with write-to-read bypass
module page_table_regs
  import process_page_controller_pkg::*;
#(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [PID_W-1:0]  waddr_i,
  input  logic [PAGE_W-1:0] wdata_i,
  input  logic [PID_W-1:0]  raddr_i,
  output logic [PAGE_W-1:0] rdata_o
);

  logic [PAGE_W-1:0] mem_q [NUM_PROCS];

  // Table storage: cleared on reset, one write per cycle
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROCS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // A same-cycle write to the slot being read is forwarded so LOAD sees it
  assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/process_page_controller.sv
// rtl/process_page_controller.sv - page table, context-switch sequencer, time slice and bounds check ahead of the MMU
module process_page_controller
  import process_page_controller_pkg::*;
#(
  parameter int NUM_PROCS = 8,
  parameter int PID_W     = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              bios_done,
  input  logic              tbl_we,
  input  logic [PID_W-1:0]  tbl_pid,
  input  logic [15:0]       tbl_base,
  input  logic [15:0]       tbl_limit,
  input  logic              sw_req,
  input  logic [PID_W-1:0]  sw_pid,
  input  logic              pipe_idle,
  input  logic [15:0]       quantum,
  input  logic              mem_access,
  input  logic [31:0]       logical_addr,
  output logic              BiosSign,
  output logic [PAGE_W-1:0] Page,
  output logic [PID_W-1:0]  cur_pid,
  output logic              sw_ack,
  output logic              preempt,
  output logic              bound_fault
);

  state_e            state_q, state_d;
  logic [PID_W-1:0]  target_q, target_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [PID_W-1:0]  cur_pid_q, cur_pid_d;
  logic              bios_sign_q, bios_sign_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              sw_ack_q, sw_ack_d;
  logic              preempt_q, preempt_d;
  logic              fault_q, fault_d;
  logic [PAGE_W-1:0] tbl_rdata;
  logic [15:0]       cur_limit;

  page_table_regs #(
    .NUM_PROCS (NUM_PROCS),
    .PID_W     (PID_W)
  ) u_page_table (
    .clock   (clock),
    .rst_n   (rst_n),
    .we_i    (tbl_we),
    .waddr_i (tbl_pid),
    .wdata_i (make_page(tbl_base, tbl_limit)),
    .raddr_i (target_q),
    .rdata_o (tbl_rdata)
  );

  assign cur_limit = page_q[PAGE_LIMIT_LSB +: PAGE_LIMIT_W];

  // All outputs come straight from registers
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BIOS;
      target_q    <= '0;
      page_q      <= '0;
      cur_pid_q   <= '0;
      bios_sign_q <= 1'b1;
      cnt_q       <= '0;
      sw_ack_q    <= 1'b0;
      preempt_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      page_q      <= page_d;
      cur_pid_q   <= cur_pid_d;
      bios_sign_q <= bios_sign_d;
      cnt_q       <= cnt_d;
      sw_ack_q    <= sw_ack_d;
      preempt_q   <= preempt_d;
      fault_q     <= fault_d;
    end
  end

  // Switch sequencing, time-slice countdown and user-mode bounds check
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    page_d      = page_q;
    cur_pid_d   = cur_pid_q;
    bios_sign_d = bios_sign_q;
    cnt_d       = cnt_q;
    sw_ack_d    = 1'b0;
    preempt_d   = 1'b0;
    fault_d     = 1'b0;
    unique case (state_q)
      ST_BIOS: begin
        if (bios_done) begin
          target_d = '0;
          state_d  = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (sw_req) begin
          target_d = sw_pid;
          state_d  = ST_DRAIN;
        end
        // A zero counter with a live quantum means the quantum was just enabled: arm it
        if (quantum != '0) begin
          if (cnt_q == 16'd1) begin
            preempt_d = 1'b1;
            cnt_d     = quantum;
          end else if (cnt_q == '0) begin
            cnt_d = quantum;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        if (mem_access && (cur_limit != '0) && (logical_addr >= {16'b0, cur_limit})) begin
          fault_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (pipe_idle) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        page_d      = tbl_rdata;
        cur_pid_d   = target_q;
        bios_sign_d = 1'b0;
        state_d     = ST_ACK;
      end
      ST_ACK: begin
        sw_ack_d = 1'b1;
        cnt_d    = quantum;
        state_d  = ST_RUN;
      end
      default: state_d = ST_BIOS;
    endcase
  end

  assign BiosSign    = bios_sign_q;
  assign Page        = page_q;
  assign cur_pid     = cur_pid_q;
  assign sw_ack      = sw_ack_q;
  assign preempt     = preempt_q;
  assign bound_fault = fault_q;

endmodule

// File: tb/tb_process_page_controller.sv
// tb/tb_process_page_controller.sv - directed self-checking bench for process_page_controller
module tb_process_page_controller;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        bios_done;
  logic        tbl_we;
  logic [2:0]  tbl_pid;
  logic [15:0] tbl_base;
  logic [15:0] tbl_limit;
  logic        sw_req;
  logic [2:0]  sw_pid;
  logic        pipe_idle;
  logic [15:0] quantum;
  logic        mem_access;
  logic [31:0] logical_addr;
  logic        BiosSign;
  logic [31:0] Page;
  logic [2:0]  cur_pid;
  logic        sw_ack;
  logic        preempt;
  logic        bound_fault;

  int n_checks = 0;
  int n_fail   = 0;

  process_page_controller #(.NUM_PROCS(8), .PID_W(3)) dut (
    .clock        (clock),
    .rst_n        (rst_n),
    .bios_done    (bios_done),
    .tbl_we       (tbl_we),
    .tbl_pid      (tbl_pid),
    .tbl_base     (tbl_base),
    .tbl_limit    (tbl_limit),
    .sw_req       (sw_req),
    .sw_pid       (sw_pid),
    .pipe_idle    (pipe_idle),
    .quantum      (quantum),
    .mem_access   (mem_access),
    .logical_addr (logical_addr),
    .BiosSign     (BiosSign),
    .Page         (Page),
    .cur_pid      (cur_pid),
    .sw_ack       (sw_ack),
    .preempt      (preempt),
    .bound_fault  (bound_fault)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tbl_write(input logic [2:0] pid, input logic [15:0] base, input logic [15:0] limit);
    tbl_we    = 1'b1;
    tbl_pid   = pid;
    tbl_base  = base;
    tbl_limit = limit;
    step();
    tbl_we    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; bios_done = 1'b0; tbl_we = 1'b0; tbl_pid = '0; tbl_base = '0; tbl_limit = '0;
    sw_req = 1'b0; sw_pid = '0; pipe_idle = 1'b0; quantum = '0; mem_access = 1'b0; logical_addr = '0;
    step(); step();
    check_val("rst_bios_sign", BiosSign, 1);
    check_val("rst_page", Page, 32'h0);
    check_val("rst_cur_pid", cur_pid, 0);
    check_val("rst_sw_ack", sw_ack, 0);
    check_val("rst_preempt", preempt, 0);
    check_val("rst_fault", bound_fault, 0);
    rst_n = 1'b1;

    tbl_write(3'd0, 16'h0100, 16'h0040);
    tbl_write(3'd3, 16'h0200, 16'h0080);

    bios_done = 1'b1;
    step();
    bios_done = 1'b0;
    check_val("boot_bios_sign_edge1", BiosSign, 1);
    step();
    check_val("boot_bios_sign_edge2", BiosSign, 0);
    check_val("boot_page", Page, 32'h01000040);
    check_val("boot_cur_pid", cur_pid, 0);
    check_val("boot_ack_early", sw_ack, 0);
    step();
    check_val("boot_ack", sw_ack, 1);
    step();
    check_val("boot_ack_once", sw_ack, 0);

    quantum = 16'd4; sw_req = 1'b1; sw_pid = 3'd3; pipe_idle = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("drain_page_hold", Page, 32'h01000040);
      check_val("drain_no_preempt", preempt, 0);
    end
    pipe_idle = 1'b1;
    step();
    check_val("load_page_hold", Page, 32'h01000040);
    step();
    check_val("sw3_page", Page, 32'h02000080);
    check_val("sw3_cur_pid", cur_pid, 3);
    check_val("sw3_ack_early", sw_ack, 0);
    check_val("sw3_no_preempt", preempt, 0);
    step();
    check_val("sw3_ack", sw_ack, 1);
    sw_req = 1'b0;

    for (int k = 1; k <= 12; k++) begin
      step();
      check_val($sformatf("q4_preempt_k%0d", k), preempt, ((k % 4) == 0) ? 1 : 0);
    end
    quantum = 16'd0;
    for (int k = 0; k < 8; k++) begin
      step();
      check_val("q0_no_preempt", preempt, 0);
    end

    mem_access = 1'b1; logical_addr = 32'h0000007F;
    step();
    check_val("bound_7f", bound_fault, 0);
    logical_addr = 32'h00000080;
    step();
    check_val("bound_80", bound_fault, 1);
    mem_access = 1'b0;
    step();
    check_val("bound_pulse", bound_fault, 0);
    mem_access = 1'b1; logical_addr = 32'h00010000;
    step();
    check_val("bound_10000", bound_fault, 1);
    mem_access = 1'b0;
    step();

    sw_req = 1'b1; sw_pid = 3'd5; pipe_idle = 1'b1;
    step();
    step();
    check_val("byp_load_hold", Page, 32'h02000080);
    tbl_we = 1'b1; tbl_pid = 3'd5; tbl_base = 16'h0300; tbl_limit = 16'h0000;
    step();
    tbl_we = 1'b0;
    check_val("byp_page", Page, 32'h03000000);
    check_val("byp_cur_pid", cur_pid, 5);
    step();
    check_val("byp_ack", sw_ack, 1);
    sw_req = 1'b0;

    mem_access = 1'b1; logical_addr = 32'hFFFFFFFF;
    step();
    check_val("lim0_ffffffff", bound_fault, 0);
    logical_addr = 32'h00010000;
    step();
    check_val("lim0_10000", bound_fault, 0);
    mem_access = 1'b0;

    tbl_write(3'd5, 16'h0400, 16'h0010);
    step();
    check_val("active_write_page", Page, 32'h03000000);

    sw_req = 1'b1; sw_pid = 3'd3; pipe_idle = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_bios_sign", BiosSign, 1);
    check_val("mid_rst_page", Page, 32'h0);
    check_val("mid_rst_cur_pid", cur_pid, 0);
    step();
    rst_n = 1'b1; pipe_idle = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check_val("post_rst_no_ack", sw_ack, 0);
      check_val("post_rst_bios", BiosSign, 1);
    end
    sw_req = 1'b0; bios_done = 1'b1;
    step();
    bios_done = 1'b0;
    step();
    check_val("reboot_bios_sign", BiosSign, 0);
    check_val("reboot_page_cleared", Page, 32'h0);
    check_val("reboot_cur_pid", cur_pid, 0);
    step();
    check_val("reboot_ack", sw_ack, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
